// File: rtl/jt5205_seq_if.sv
// ROM fetch bus between the ADPCM sequencer (master) and the sample ROM (slave).
// The master holds rom_addr stable and keeps rom_cs up until rom_ok answers.
interface jt5205_seq_if #(
   parameter int AW = 16
);
   logic [AW-1:0] rom_addr;
   logic          rom_cs;
   logic [7:0]    rom_data;
   logic          rom_ok;

   modport master (
      output rom_addr,
      output rom_cs,
      input  rom_data,
      input  rom_ok
   );

   modport slave (
      input  rom_addr,
      input  rom_cs,
      output rom_data,
      output rom_ok
   );
endinterface

// File: rtl/jt5205_seq.sv
// ADPCM playback sequencer: fetches bytes start..end from ROM and feeds the
// decoder one nibble (high first) per cen_lo, with a one-byte prefetch buffer.
module jt5205_seq #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen_lo,
   input  logic          start,
   input  logic          stop,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] end_addr,
   jt5205_seq_if.master  rom,
   output logic [3:0]    din,
   output logic          dec_rst,
   output logic          busy,
   output logic          done,
   output logic          underrun
);

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      PLAY,
      WAIT
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [AW-1:0] addr;
   logic [AW-1:0] last_addr;
   logic [7:0]    cur;
   logic [7:0]    nxt;
   logic          cur_vld;
   logic          nxt_vld;
   logic          phase;
   logic          more;
   logic          cs;
   logic          fetch_ok;
   logic          nib_step;
   logic          end_step;
   logic          starve;

   // "more" means bytes are still to be fetched; it avoids comparing a wrapped
   // address against the end address.
   assign cs       = (state == FIRST) || (state == WAIT) ||
                     ((state == PLAY) && !nxt_vld && more);
   assign fetch_ok = cs && rom.rom_ok;
   assign nib_step = (state == PLAY) && cen_lo && cur_vld;
   assign end_step = (state == PLAY) && cen_lo && !cur_vld;
   assign starve   = nib_step && phase && !nxt_vld && more;

   assign rom.rom_cs   = cs;
   assign rom.rom_addr = addr;
   assign busy         = (state != IDLE);
   assign dec_rst      = (state == IDLE) || (state == FIRST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = IDLE;
         FIRST:   if (fetch_ok) state_nx = PLAY;
         PLAY: begin
            if (end_step) begin
               state_nx = IDLE;
            end else if (starve && !fetch_ok) begin
               state_nx = WAIT;
            end
         end
         WAIT:    if (fetch_ok) state_nx = PLAY;
         default: state_nx = IDLE;
      endcase
      if (start) state_nx = FIRST;
      if (stop)  state_nx = IDLE;
   end

   // A byte arriving in the same cycle as a starving low-nibble step goes
   // straight to the current buffer, just as it would after a WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         last_addr <= '0;
         cur       <= '0;
         nxt       <= '0;
         cur_vld   <= 1'b0;
         nxt_vld   <= 1'b0;
         phase     <= 1'b0;
         more      <= 1'b0;
         din       <= '0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            cur_vld <= 1'b0;
            nxt_vld <= 1'b0;
            phase   <= 1'b0;
         end else if (start) begin
            addr      <= start_addr;
            last_addr <= (end_addr < start_addr) ? start_addr : end_addr;
            more      <= 1'b1;
            underrun  <= 1'b0;
            phase     <= 1'b0;
            cur_vld   <= 1'b0;
            nxt_vld   <= 1'b0;
         end else begin
            if (end_step) done <= 1'b1;
            if (nib_step) begin
               if (!phase) begin
                  din   <= cur[7:4];
                  phase <= 1'b1;
               end else begin
                  din   <= cur[3:0];
                  phase <= 1'b0;
                  if (nxt_vld) begin
                     cur     <= nxt;
                     nxt_vld <= 1'b0;
                  end else if (more) begin
                     underrun <= 1'b1;
                  end else begin
                     cur_vld <= 1'b0;
                  end
               end
            end
            if (fetch_ok) begin
               addr <= addr + 1'b1;
               more <= (addr != last_addr);
               if ((state == PLAY) && !starve) begin
                  nxt     <= rom.rom_data;
                  nxt_vld <= 1'b1;
               end else begin
                  cur     <= rom.rom_data;
                  cur_vld <= 1'b1;
                  phase   <= 1'b0;
               end
            end
         end
      end
   end

endmodule
